// File: rtl/if_fetch.sv
// Instruction-fetch stage: one imem request per PC over req/ack, PC-enable generation,
// registered instruction/PC toward decode, and squashing of wrong-path fetches on redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic [31:0] in_npc,
  input  logic        in_stall,
  input  logic        in_flush,
  input  logic        in_imem_ack,
  input  logic [31:0] in_imem_rdata,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  output logic        out_pc_ena,
  output logic [31:0] out_inst,
  output logic [31:0] out_inst_pc,
  output logic        out_valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] redir_q, redir_nxt;
  logic [31:0] buf_q, buf_nxt;
  logic [31:0] load_inst;
  logic        ready;
  logic        load;

  assign ready         = ~in_stall | ~out_valid;
  assign out_imem_req  = (state == REQ) || (state == DROP);
  assign out_imem_addr = addr_q;

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    redir_nxt  = redir_q;
    buf_nxt    = buf_q;
    load       = 1'b0;
    load_inst  = in_imem_rdata;
    out_pc_ena = in_flush;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (in_flush) begin
          if (in_imem_ack) begin
            addr_nxt = in_npc;
          end else begin
            redir_nxt = in_npc;
            state_nxt = DROP;
          end
        end else if (in_imem_ack) begin
          if (ready) begin
            load       = 1'b1;
            addr_nxt   = in_npc;
            out_pc_ena = 1'b1;
          end else begin
            // Decode is full: park the word and keep the PC where it is.
            buf_nxt   = in_imem_rdata;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (in_flush) begin
          addr_nxt  = in_npc;
          state_nxt = REQ;
        end else if (ready) begin
          load       = 1'b1;
          load_inst  = buf_q;
          addr_nxt   = in_npc;
          out_pc_ena = 1'b1;
          state_nxt  = REQ;
        end
      end
      DROP: begin
        // Stale request still owns the bus; remember the newest redirect target.
        if (in_flush) redir_nxt = in_npc;
        if (in_imem_ack) begin
          addr_nxt  = in_flush ? in_npc : redir_q;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state   <= IDLE;
      addr_q  <= RESET_PC;
      redir_q <= '0;
      buf_q   <= '0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      redir_q <= redir_nxt;
      buf_q   <= buf_nxt;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_inst    <= '0;
      out_inst_pc <= '0;
      out_valid   <= 1'b0;
    end else if (in_flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_inst    <= load_inst;
      out_inst_pc <= addr_q;
      out_valid   <= 1'b1;
    end else if (out_valid && !in_stall) begin
      out_valid <= 1'b0;
    end
  end

endmodule
